// File: rtl/matmul_sequencer.sv
// Job controller for the 4-bit matrix-multiply accelerator: loads W and X into the
// bank from a host stream, then walks every output element issuing reads and MAC strobes.
module matmul_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] row_w,
  input  logic [1:0] col_w,
  input  logic [1:0] row_x,
  input  logic [1:0] col_x,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       busy,
  output logic       err_dim,
  output logic       mem_clear,
  output logic       mem_we,
  output logic       mem_sel,
  output logic [3:0] mem_addr,
  output logic [3:0] mem_wdata,
  output logic [3:0] w_rd_addr,
  output logic [3:0] x_rd_addr,
  output logic       mac_clear,
  output logic       mac_ld,
  output logic       out_valid,
  output logic [1:0] out_row,
  output logic [1:0] out_col,
  output logic       done,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLRMEM = 3'd1,
    S_LOAD_W = 3'd2,
    S_LOAD_X = 3'd3,
    S_CLRACC = 3'd4,
    S_MAC    = 3'd5,
    S_EMIT   = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t     state, next_state;
  logic [1:0] rw, cw, rx, cx;
  logic [3:0] ld_cnt;
  logic [1:0] i, j, k;
  logic [3:0] w_base, w_addr, x_addr;
  logic [1:0] row_q, col_q;
  logic       err_q;

  logic       dims_ok, loading, beat, load_end;
  logic       last_k, last_i, last_j;
  logic [3:0] w_total, x_total, ld_total;

  // Handshake: a load beat transfers in any cycle where in_valid and in_ready are both high.
  assign dims_ok  = (row_w != 2'd0) && (col_w != 2'd0) && (row_x != 2'd0) &&
                    (col_x != 2'd0) && (col_w == row_x);
  assign loading  = (state == S_LOAD_W) || (state == S_LOAD_X);
  assign beat     = in_valid && loading;
  assign w_total  = {2'b00, rw} * {2'b00, cw};
  assign x_total  = {2'b00, rx} * {2'b00, cx};
  assign ld_total = (state == S_LOAD_W) ? w_total : x_total;
  assign load_end = beat && (ld_cnt == ld_total - 4'd1);
  assign last_k   = (k == cw - 2'd1);
  assign last_i   = (i == rw - 2'd1);
  assign last_j   = (j == cx - 2'd1);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start && dims_ok) next_state = S_CLRMEM;
      S_CLRMEM: next_state = S_LOAD_W;
      S_LOAD_W: if (load_end) next_state = S_LOAD_X;
      S_LOAD_X: if (load_end) next_state = S_CLRACC;
      S_CLRACC: next_state = S_MAC;
      S_MAC:    if (last_k) next_state = S_EMIT;
      S_EMIT:   next_state = (last_i && last_j) ? S_DONE : S_CLRACC;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) next_state = S_IDLE;
  end

  // Read addresses advance by addition: +1 along a W row, +col_x down an X column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw <= '0; cw <= '0; rx <= '0; cx <= '0;
      ld_cnt <= '0; i <= '0; j <= '0; k <= '0;
      w_base <= '0; w_addr <= '0; x_addr <= '0;
      row_q <= '0; col_q <= '0; err_q <= 1'b0;
    end else begin
      err_q <= (state == S_IDLE) && start && !dims_ok;
      case (state)
        S_IDLE: if (start && dims_ok) begin
          rw <= row_w; cw <= col_w; rx <= row_x; cx <= col_x;
          ld_cnt <= '0; i <= '0; j <= '0; k <= '0; w_base <= '0;
        end
        S_LOAD_W, S_LOAD_X: if (beat) ld_cnt <= load_end ? 4'd0 : ld_cnt + 4'd1;
        S_CLRACC: begin
          k      <= '0;
          w_addr <= w_base;
          x_addr <= {2'b00, j};
        end
        S_MAC: begin
          k      <= k + 2'd1;
          w_addr <= w_addr + 4'd1;
          x_addr <= x_addr + {2'b00, cx};
        end
        S_EMIT: begin
          row_q <= i;
          col_q <= j;
          if (last_j) begin
            j      <= '0;
            i      <= i + 2'd1;
            w_base <= w_base + {2'b00, cw};
          end else begin
            j <= j + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = loading;
    busy      = (state != S_IDLE);
    err_dim   = err_q;
    mem_clear = 1'b0;
    mem_we    = beat;
    mem_sel   = 1'b0;
    mem_addr  = beat ? ld_cnt : 4'd0;
    mem_wdata = beat ? in_data : 4'd0;
    w_rd_addr = 4'd0;
    x_rd_addr = 4'd0;
    mac_clear = 1'b0;
    mac_ld    = 1'b0;
    out_valid = 1'b0;
    out_row   = row_q;
    out_col   = col_q;
    done      = 1'b0;
    case (state)
      S_CLRMEM: mem_clear = 1'b1;
      S_LOAD_X: mem_sel = beat;
      S_CLRACC: mac_clear = 1'b1;
      S_MAC: begin
        mac_ld    = 1'b1;
        w_rd_addr = w_addr;
        x_rd_addr = x_addr;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        out_row   = i;
        out_col   = j;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: directed jobs checked against expected write/read/emit
// queues, a bank+accumulator model, and the arithmetic matrix product.
module tb_matmul_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic [1:0] row_w = '0, col_w = '0, row_x = '0, col_x = '0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_ready, busy, err_dim, mem_clear, mem_we, mem_sel;
  logic [3:0] mem_addr, mem_wdata, w_rd_addr, x_rd_addr;
  logic       mac_clear, mac_ld, out_valid, done;
  logic [1:0] out_row, out_col;
  logic [2:0] dbg_state;

  matmul_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .row_w(row_w), .col_w(col_w), .row_x(row_x), .col_x(col_x),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
    .err_dim(err_dim), .mem_clear(mem_clear), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .w_rd_addr(w_rd_addr),
    .x_rd_addr(x_rd_addr), .mac_clear(mac_clear), .mac_ld(mac_ld),
    .out_valid(out_valid), .out_row(out_row), .out_col(out_col), .done(done),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  int last_beat_cyc = 0, mac_seen = 0, done_seen = 0, exp_lat = 0, acc = 0;
  bit done_ok = 1'b0;
  logic [8:0] wr_q[$];
  logic [7:0] mac_q[$];
  logic [3:0] emit_q[$];
  int bank_w[9], bank_x[9];
  int exp_c[3][3];
  int rw, cw, rx, cx;
  logic [3:0] wv[9], xv[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  always @(posedge clk) cyc++;

  // Compare process: every cycle out of reset, DUT activity must match the expected queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_clear) for (int a = 0; a < 9; a++) begin bank_w[a] = 0; bank_x[a] = 0; end
      if (mem_we) begin
        if (wr_q.size() == 0) fail_now("unexpected_write");
        else begin
          chk("write", {mem_sel, mem_addr, mem_wdata}, wr_q.pop_front());
          if (wr_q.size() == 0) last_beat_cyc = cyc;
        end
        if (mem_addr < 9) begin
          if (mem_sel) bank_x[mem_addr] = int'(mem_wdata);
          else         bank_w[mem_addr] = int'(mem_wdata);
        end
      end
      if (mac_clear) acc = 0;
      if (mac_ld) begin
        mac_seen++;
        if (mac_q.size() == 0) fail_now("unexpected_mac_ld");
        else chk("rd_addr", {w_rd_addr, x_rd_addr}, mac_q.pop_front());
        if (w_rd_addr < 9 && x_rd_addr < 9) acc += bank_w[w_rd_addr] * bank_x[x_rd_addr];
      end else begin
        chk("rd_addr_idle", {w_rd_addr, x_rd_addr}, 0);
      end
      if (out_valid) begin
        if (emit_q.size() == 0) fail_now("unexpected_out_valid");
        else chk("emit_index", {out_row, out_col}, emit_q.pop_front());
        if (out_row < 3 && out_col < 3) chk("emit_value", acc, exp_c[out_row][out_col]);
      end
      if (done) begin
        if (!done_ok) fail_now("unexpected_done");
        else chk("done_latency", cyc - last_beat_cyc, exp_lat);
        done_ok = 1'b0;
        done_seen++;
      end
    end
  end

  task automatic build_expect(input int wr_lim, input int mac_lim, input bit full);
    int n, m;
    n = 0; m = 0;
    wr_q.delete(); mac_q.delete(); emit_q.delete();
    for (int a = 0; a < rw * cw; a++) begin
      if (n < wr_lim) wr_q.push_back({1'b0, 4'(a), wv[a]});
      n++;
    end
    for (int a = 0; a < rx * cx; a++) begin
      if (n < wr_lim) wr_q.push_back({1'b1, 4'(a), xv[a]});
      n++;
    end
    for (int i = 0; i < rw; i++)
      for (int j = 0; j < cx; j++) begin
        exp_c[i][j] = 0;
        for (int k = 0; k < cw; k++) begin
          exp_c[i][j] += int'(wv[i * cw + k]) * int'(xv[k * cx + j]);
          if (m < mac_lim) mac_q.push_back({4'(i * cw + k), 4'(k * cx + j)});
          m++;
        end
        if (m <= mac_lim) emit_q.push_back({2'(i), 2'(j)});
      end
    done_ok = full;
    exp_lat = rw * cx * (cw + 2) + 1;
  endtask

  task automatic do_start(input int a, input int b, input int c, input int d, input bit with_abort);
    @(posedge clk); #1;
    start = 1'b1; abort = with_abort;
    row_w = 2'(a); col_w = 2'(b); row_x = 2'(c); col_x = 2'(d);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    row_w = '0; col_w = '0; row_x = '0; col_x = '0;
  endtask

  task automatic send_beats(input bit gaps, input int abort_at, input int busy_start_at);
    int idx, total, budget;
    bit go, xfer, aborted;
    idx = 0; budget = 0; aborted = 0;
    total = rw * cw + rx * cx;
    while (idx < total && budget < 400 && !aborted) begin
      go = !gaps || ($urandom_range(0, 2) != 0);
      in_valid = go;
      in_data  = (idx < rw * cw) ? wv[idx] : xv[idx - rw * cw];
      abort    = go && (idx == abort_at);
      start    = (idx == busy_start_at);
      if (start) begin row_w = 2'd3; col_w = 2'd3; row_x = 2'd3; col_x = 2'd3; end
      @(negedge clk);
      xfer = in_valid && in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (xfer) begin
        if (abort) aborted = 1'b1;
        idx++;
      end
      abort = 1'b0;
      budget++;
    end
    in_valid = 1'b0;
    row_w = '0; col_w = '0; row_x = '0; col_x = '0;
    if (budget >= 400) fail_now("stream_timeout");
    if (aborted) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk("abort_load_idle", busy, 0);
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n, d0;
    n = 0; d0 = done_seen;
    while (done_seen == d0 && n < 300) begin @(posedge clk); n++; end
    if (done_seen == d0) fail_now("done_timeout");
    @(negedge clk);
    chk("done_single_pulse", done, 0);
    chk("queues_drained", wr_q.size() + mac_q.size() + emit_q.size(), 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic wait_macs(input int n_macs);
    int n, base;
    n = 0; base = mac_seen;
    while (mac_seen < base + n_macs && n < 300) begin @(negedge clk); #1; n++; end
    if (mac_seen < base + n_macs) fail_now("mac_timeout");
  endtask

  task automatic illegal(input int a, input int b, input int c, input int d);
    @(posedge clk); #1;
    start = 1'b1;
    row_w = 2'(a); col_w = 2'(b); row_x = 2'(c); col_x = 2'(d);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("err_dim_pulse", err_dim, 1);
    chk("err_busy", busy, 0);
    @(negedge clk);
    chk("err_dim_clear", err_dim, 0);
    chk("err_busy_after", busy, 0);
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {busy, in_ready, err_dim, mem_clear, mem_we, mem_sel, mem_addr, mem_wdata,
               mac_clear, mac_ld, out_valid, out_row, out_col, done, dbg_state}, 0);
    chk({name, "_rd"}, {w_rd_addr, x_rd_addr}, 0);
  endtask

  task automatic set_2x2(input int base);
    rw = 2; cw = 2; rx = 2; cx = 2;
    for (int a = 0; a < 9; a++) begin
      wv[a] = (a < 4) ? 4'(base + a) : 4'd0;
      xv[a] = (a < 4) ? 4'(base + 4 + a) : 4'd0;
    end
  endtask

  initial begin
    #2;
    check_all_zero("reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 2x2 * 2x2, continuous stream, start pulses during LOAD_W and EMIT
    set_2x2(1);
    build_expect(99, 99, 1);
    chk("model_c00", exp_c[0][0], 19);
    chk("model_c01", exp_c[0][1], 22);
    chk("model_c10", exp_c[1][0], 43);
    chk("model_c11", exp_c[1][1], 50);
    chk("model_latency", exp_lat, 17);
    chk("model_mac_01", {mac_q[2], mac_q[3]}, 16'h01_13);
    chk("model_mac_10", {mac_q[4], mac_q[5]}, 16'h20_32);
    do_start(2, 2, 2, 2, 0);
    send_beats(0, -1, 2);
    begin
      int n = 0;
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      start = 1'b1; row_w = 2'd1; col_w = 2'd1; row_x = 2'd1; col_x = 2'd1;
      @(posedge clk); #1;
      start = 1'b0; row_w = '0; col_w = '0; row_x = '0; col_x = '0;
    end
    wait_done();

    // 3x3 * 3x1 with random in_valid gaps; abort in IDLE alongside start
    rw = 3; cw = 3; rx = 3; cx = 1;
    for (int a = 0; a < 9; a++) begin wv[a] = 4'(a + 1); xv[a] = (a < 3) ? 4'(a + 1) : 4'd0; end
    build_expect(99, 99, 1);
    chk("model3_c00", exp_c[0][0], 14);
    chk("model3_c10", exp_c[1][0], 32);
    chk("model3_c20", exp_c[2][0], 50);
    chk("model3_latency", exp_lat, 16);
    chk("model3_mac_20", {mac_q[6], mac_q[7], mac_q[8]}, 24'h60_71_82);
    do_start(3, 3, 3, 1, 1);
    send_beats(1, -1, -1);
    wait_done();

    // illegal dimensions
    illegal(1, 2, 3, 1);
    illegal(0, 1, 1, 1);

    // abort on LOAD_X beat 2
    set_2x2(2);
    build_expect(7, 0, 0);
    do_start(2, 2, 2, 2, 0);
    send_beats(0, 6, -1);
    chk("abort_load_drained", wr_q.size(), 0);

    // abort during MAC on the third mac_ld cycle
    set_2x2(3);
    build_expect(99, 3, 0);
    do_start(2, 2, 2, 2, 0);
    send_beats(0, -1, -1);
    wait_macs(3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_mac_ld_drop", mac_ld, 0);
    chk("abort_mac_idle", busy, 0);
    repeat (3) @(negedge clk);
    chk("abort_mac_drained", mac_q.size() + emit_q.size(), 0);

    // reset in the middle of MAC, then a clean job
    set_2x2(4);
    build_expect(99, 99, 1);
    do_start(2, 2, 2, 2, 0);
    send_beats(0, -1, -1);
    wait_macs(1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset_mid_mac");
    wr_q.delete(); mac_q.delete(); emit_q.delete();
    done_ok = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_2x2(5);
    build_expect(99, 99, 1);
    do_start(2, 2, 2, 2, 0);
    send_beats(0, -1, -1);
    wait_done();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

endmodule
